// File: rtl/alu_resp_pkg.sv
// Shared mode encodings, FSM state type and mode classification helpers for alu_resp.
package alu_resp_pkg;

   localparam logic [7:0] MODE_ADD  = 8'd0;
   localparam logic [7:0] MODE_SUB  = 8'd1;
   localparam logic [7:0] MODE_RSUB = 8'd2;
   localparam logic [7:0] MODE_MUL  = 8'd3;
   localparam logic [7:0] MODE_SHR  = 8'd4;
   localparam logic [7:0] MODE_SHL  = 8'd5;
   localparam logic [7:0] MODE_RSHR = 8'd6;
   localparam logic [7:0] MODE_RSHL = 8'd7;
   localparam logic [7:0] MODE_XOR  = 8'd8;
   localparam logic [7:0] MODE_MAX  = 8'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic mode_supported(input logic [7:0] mode);
      return mode <= MODE_MAX;
   endfunction

   // Only the multiply spends more than one cycle in CALC.
   function automatic logic mode_multi_cycle(input logic [7:0] mode);
      return mode == MODE_MUL;
   endfunction

endpackage

// File: rtl/alu_resp_mul.sv
// Serial shift-add multiplier: one multiplier bit per cycle, LSB first, truncated product.
module alu_resp_mul
   import alu_resp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_nxt;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;

   // The last partial product is folded in combinationally, so the full
   // product is presented on the same cycle done is asserted.
   always_comb begin
      acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
      done    = busy_q && (cnt_q == CW'(WIDTH - 1));
      product = acc_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start) begin
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_nxt;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (done) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_resp.sv
// Single-outstanding ALU with valid/ready request and response handshakes.
module alu_resp
   import alu_resp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             emu_clk,
   input  logic             emu_rst,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [7:0]       mode_in,
   input  logic             req_valid,
   output logic             req_ready,
   output logic [WIDTH-1:0] c_out,
   output logic             err,
   output logic             rsp_valid,
   input  logic             rsp_ready
);

   state_t           state_q, state_d;
   logic             rst_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [7:0]       mode_q;
   logic [WIDTH-1:0] c_q;
   logic             err_q;
   logic [WIDTH-1:0] result;
   logic             accept;
   logic             rsp_fire;
   logic             calc_last;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   assign accept    = req_valid && req_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign mul_start = accept && mode_multi_cycle(mode_in);
   assign calc_last = mode_multi_cycle(mode_q) ? mul_done : 1'b1;

   alu_resp_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (emu_clk),
      .rst     (emu_rst),
      .start   (mul_start),
      .a       (a_in),
      .b       (b_in),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge emu_clk) begin
      if (emu_rst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)    state_d = ST_CALC;
         ST_CALC: if (calc_last) state_d = ST_DONE;
         ST_DONE: if (rsp_fire)  state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // req_ready is held low through reset via a registered copy of the
   // reset so that no input reaches the outputs combinationally.
   always_comb begin
      req_ready = (state_q == ST_IDLE) && !rst_q;
      rsp_valid = (state_q == ST_DONE);
      c_out     = c_q;
      err       = err_q;
   end

   always_comb begin
      result = '0;
      case (mode_q)
         MODE_ADD:  result = a_q + b_q;
         MODE_SUB:  result = a_q - b_q;
         MODE_RSUB: result = b_q - a_q;
         MODE_MUL:  result = mul_product;
         MODE_SHR:  result = a_q >> b_q[2:0];
         MODE_SHL:  result = a_q << b_q[2:0];
         MODE_RSHR: result = b_q >> a_q[2:0];
         MODE_RSHL: result = b_q << a_q[2:0];
         MODE_XOR:  result = a_q ^ b_q;
         default:   result = '0;
      endcase
   end

   always_ff @(posedge emu_clk) begin
      rst_q <= emu_rst;
      if (emu_rst) begin
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= '0;
         c_q    <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            a_q    <= a_in;
            b_q    <= b_in;
            mode_q <= mode_in;
         end
         if (state_q == ST_CALC && calc_last) begin
            c_q   <= result;
            err_q <= !mode_supported(mode_q);
         end
      end
   end

endmodule

// File: tb/tb_alu_resp.sv
// Self-checking bench for alu_resp: directed vector table, corner sequences, random ops vs. model.
module tb_alu_resp;

   localparam int WIDTH = 8;
   localparam int MOD   = 1 << WIDTH;

   logic             emu_clk = 1'b0;
   logic             emu_rst = 1'b1;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic [7:0]       mode_in = '0;
   logic             req_valid = 1'b0;
   logic             rsp_ready = 1'b1;
   logic             req_ready;
   logic [WIDTH-1:0] c_out;
   logic             err;
   logic             rsp_valid;

   int n_chk  = 0;
   int n_pass = 0;

   alu_resp #(.WIDTH(WIDTH)) dut (
      .emu_clk   (emu_clk),
      .emu_rst   (emu_rst),
      .a_in      (a_in),
      .b_in      (b_in),
      .mode_in   (mode_in),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .c_out     (c_out),
      .err       (err),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready)
   );

   always #5 emu_clk = ~emu_clk;

   typedef struct {
      int a; int b; int m; int c; int e; int lat;
   } vec_t;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   function automatic int ref_c(input int a, input int b, input int m);
      case (m)
         0: return (a + b) % MOD;
         1: return (a - b + MOD) % MOD;
         2: return (b - a + MOD) % MOD;
         3: return (a * b) % MOD;
         4: return a / (1 << (b % 8));
         5: return (a * (1 << (b % 8))) % MOD;
         6: return b / (1 << (a % 8));
         7: return (b * (1 << (a % 8))) % MOD;
         8: return a ^ b;
         default: return 0;
      endcase
   endfunction

   // Latency counted in rising edges from the accepting edge (inclusive) to rsp_valid.
   function automatic int ref_lat(input int m);
      return (m == 3) ? WIDTH + 1 : 2;
   endfunction

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge emu_clk); #1;
         n++;
      end
      ok = req_ready;
   endtask

   task automatic run_op(input int a, input int b, input int m,
                         output int c, output int e, output int lat, output bit ok);
      bit rdy;
      c = 0; e = 0; lat = 0; ok = 0;
      wait_ready(rdy);
      if (!rdy) return;
      a_in = WIDTH'(a); b_in = WIDTH'(b); mode_in = 8'(m); req_valid = 1'b1;
      @(posedge emu_clk); #1;
      req_valid = 1'b0;
      a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); mode_in = 8'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge emu_clk); #1;
         lat++;
      end
      if (!rsp_valid) return;
      c = int'(c_out); e = int'(err); ok = 1;
   endtask

   initial begin
      vec_t tbl[$];
      int c, e, lat, seen;
      bit ok;
      int acc[$];

      tbl.push_back('{12, 34, 0, 46, 0, 2});
      tbl.push_back('{3, 7, 3, 21, 0, 9});
      tbl.push_back('{20, 13, 3, 4, 0, 9});
      tbl.push_back('{45, 10, 1, 35, 0, 2});
      tbl.push_back('{10, 44, 2, 34, 0, 2});
      tbl.push_back('{9, 1, 4, 4, 0, 2});
      tbl.push_back('{9, 1, 5, 18, 0, 2});
      tbl.push_back('{2, 32, 6, 8, 0, 2});
      tbl.push_back('{3, 3, 7, 24, 0, 2});
      tbl.push_back('{56, 78, 8, 118, 0, 2});
      tbl.push_back('{1, 1, 9, 0, 1, 2});
      tbl.push_back('{1, 1, 0, 2, 0, 2});
      tbl.push_back('{255, 255, 3, 1, 0, 9});
      tbl.push_back('{0, 5, 1, 251, 0, 2});
      tbl.push_back('{200, 100, 0, 44, 0, 2});
      tbl.push_back('{7, 9, 255, 0, 1, 2});

      // Reset state
      repeat (3) @(posedge emu_clk);
      #1;
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_c_out", int'(c_out), 0);
      chk("rst_err", int'(err), 0);
      emu_rst = 1'b0;
      @(posedge emu_clk); #1;
      chk("post_rst_req_ready", int'(req_ready), 1);

      // Directed vectors
      foreach (tbl[i]) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].m, c, e, lat, ok);
         if (!ok) chk($sformatf("vec%0d_timeout", i), 0, 1);
         else begin
            chk($sformatf("vec%0d_c", i), c, tbl[i].c);
            chk($sformatf("vec%0d_err", i), e, tbl[i].e);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
         end
      end

      // Back-to-back issue with req_valid held high
      wait_ready(ok);
      if (!ok) chk("b2b_timeout", 0, 1);
      a_in = 8'd1; b_in = 8'd2; mode_in = 8'd0; req_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge emu_clk);
         if (req_ready) acc.push_back(i);
         @(posedge emu_clk);
      end
      #1 req_valid = 1'b0;
      chk("b2b_count", acc.size(), 3);
      for (int i = 0; i < acc.size(); i++) chk($sformatf("b2b_idx%0d", i), acc[i], 3 * i);
      chk("b2b_c_out", int'(c_out), 3);

      // Backpressure
      rsp_ready = 1'b0;
      run_op(12, 34, 0, c, e, lat, ok);
      if (!ok) chk("bp_timeout", 0, 1);
      chk("bp_c", c, 46);
      for (int i = 0; i < 5; i++) begin
         a_in = 8'($urandom); req_valid = 1'b1;
         @(posedge emu_clk); #1;
         chk($sformatf("bp%0d_rsp_valid", i), int'(rsp_valid), 1);
         chk($sformatf("bp%0d_c_out", i), int'(c_out), 46);
         chk($sformatf("bp%0d_err", i), int'(err), 0);
         chk($sformatf("bp%0d_req_ready", i), int'(req_ready), 0);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge emu_clk); #1;
      chk("bp_release_rsp_valid", int'(rsp_valid), 0);
      chk("bp_release_c_hold", int'(c_out), 46);
      chk("bp_release_req_ready", int'(req_ready), 1);

      // Reset in the middle of a multiply
      wait_ready(ok);
      a_in = 8'd3; b_in = 8'd7; mode_in = 8'd3; req_valid = 1'b1;
      @(posedge emu_clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge emu_clk);
      #1 emu_rst = 1'b1;
      @(posedge emu_clk); #1;
      chk("mrst_rsp_valid", int'(rsp_valid), 0);
      chk("mrst_c_out", int'(c_out), 0);
      chk("mrst_req_ready_low", int'(req_ready), 0);
      emu_rst = 1'b0;
      @(posedge emu_clk); #1;
      chk("mrst_req_ready", int'(req_ready), 1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge emu_clk); #1;
         if (rsp_valid) seen++;
      end
      chk("mrst_no_rsp", seen, 0);
      chk("mrst_c_after", int'(c_out), 0);
      run_op(5, 6, 0, c, e, lat, ok);
      chk("mrst_recover_c", ok ? c : -1, 11);

      // Random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         int ra, rb, rm;
         ra = int'($urandom_range(0, MOD - 1));
         rb = int'($urandom_range(0, MOD - 1));
         rm = int'($urandom_range(0, 11));
         run_op(ra, rb, rm, c, e, lat, ok);
         if (!ok) chk($sformatf("rnd%0d_timeout", i), 0, 1);
         else begin
            chk($sformatf("rnd%0d_c(%0d,%0d,m%0d)", i, ra, rb, rm), c, ref_c(ra, rb, rm));
            chk($sformatf("rnd%0d_err", i), e, (rm > 8) ? 1 : 0);
            chk($sformatf("rnd%0d_lat", i), lat, ref_lat(rm));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_resp.md
ALU_RESP -- requirements
Module: alu_resp

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 emu_clk  input  1  emulator clock; all state updates on its rising edge.
REQ-004 emu_rst  input  1  synchronous active-high reset.
REQ-005 a_in  input  WIDTH  operand A, sampled on request acceptance.
REQ-006 b_in  input  WIDTH  operand B, sampled on request acceptance.
REQ-007 mode_in  input  8  operation select, sampled on request acceptance.
REQ-008 req_valid  input  1  requester has a valid operation on a_in/b_in/mode_in.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 c_out  output  WIDTH  result; stable while rsp_valid is high.
REQ-011 err  output  1  unsupported mode flag; qualified by rsp_valid.
REQ-012 rsp_valid  output  1  c_out/err hold a response.
REQ-013 rsp_ready  input  1  consumer accepts the response this cycle.

Function
REQ-014 FSM states: IDLE, CALC, DONE; one request in flight, no queuing.
REQ-015 Request accepted on an edge where req_valid && req_ready; req_ready is high only in IDLE.
REQ-016 IDLE -> CALC on acceptance; operands and mode captured into internal registers; later input changes are ignored.
REQ-017 Mode 0: A+B; 1: A-B; 2: B-A; 3: A*B; 4: A>>B[2:0]; 5: A<<B[2:0]; 6: B>>A[2:0]; 7: B<<A[2:0]; 8: A^B; all results truncated modulo 2^WIDTH; shifts are logical.
REQ-018 Modes 0-2 and 4-8: one CALC cycle, then DONE; rsp_valid rises 2 cycles after the acceptance edge.
REQ-019 Mode 3: serial shift-add multiply, WIDTH CALC cycles (one multiplier bit per cycle, LSB first), then DONE; rsp_valid rises WIDTH+1 cycles after acceptance.
REQ-020 Mode >= 9: one CALC cycle, then DONE with c_out = 0 and err = 1; err = 0 for all supported modes.
REQ-021 DONE holds rsp_valid, c_out and err unchanged until rsp_valid && rsp_ready; then -> IDLE; req_ready rises the following cycle.
REQ-022 rsp_ready asserted before rsp_valid has no effect; it is not latched.
REQ-023 req_valid held high continuously: next request is accepted on the first cycle back in IDLE; minimum issue interval is 3 cycles for single-cycle modes.
REQ-024 Outside DONE, rsp_valid = 0 and c_out retains its last response value.

Reset
REQ-025 emu_rst high: state = IDLE, c_out = 0, err = 0, rsp_valid = 0, req_ready = 0 during reset, req_ready = 1 on the first cycle after reset deasserts.
REQ-026 Reset mid-CALC or mid-DONE aborts the operation; no response is produced for it.
REQ-027 Reset has priority over acceptance and response handshakes in the same cycle.

Structure
REQ-028 Shared package alu_resp_pkg holds the mode encoding constants (MODE_ADD ... MODE_XOR, MODE_MAX = 8) and the FSM state typedef.
REQ-029 Sub-module alu_resp_mul holds the serial multiplier (start, done, WIDTH-bit truncated product); alu_resp instantiates it once.
REQ-030 No combinational path from any input to req_ready, rsp_valid, c_out or err.

Verification
REQ-031 Add: A=12, B=34, mode 0, rsp_ready=1 -> c_out=46, err=0, rsp_valid 2 cycles after acceptance.
REQ-032 Mul: A=3, B=7, mode 3 -> c_out=21 at 9 cycles after acceptance; A=20, B=13 -> c_out=4 (260 mod 256).
REQ-033 Shifts and subtract: (45,10,1)->35; (10,44,2)->34; (9,1,4)->4; (9,1,5)->18; (2,32,6)->8; (3,3,7)->24; (56,78,8)->118.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> c_out/err stable, req_ready=0 throughout, changed a_in ignored.
REQ-035 Error: mode 9, A=1, B=1 -> c_out=0, err=1; next request mode 0 (1,1) -> c_out=2, err=0.
REQ-036 Reset mid-multiply: emu_rst pulsed 3 cycles after accepting (3,7,3) -> no rsp_valid, c_out=0, req_ready=1 the cycle after reset deasserts.
